// File: rtl/line_delay_ctrl.sv
// Line-delay controller: pairs each incoming pixel with the same-column pixel
// of the previous line, using an external first-word-fall-through line FIFO.
module line_delay_ctrl #(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned INIT_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  in_data,
    output logic        fifo_wre,
    output logic [7:0]  fifo_din,
    output logic        fifo_rde,
    input  logic [7:0]  fifo_dout,
    output logic        out_valid,
    output logic [7:0]  out_cur,
    output logic [7:0]  out_prev,
    output logic        out_prev_ok,
    output logic [11:0] out_col,
    output logic [11:0] out_row,
    output logic        drop_err
);

    localparam int unsigned CW      = 12;
    localparam int unsigned OCC_W   = $clog2(LINE_WIDTH + 1);
    localparam int unsigned WAIT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WAIT_CW = WAIT_W + 1;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CW-1:0]      col;
    logic [CW-1:0]      row;
    logic [OCC_W-1:0]   occ;

    logic wait_done_c;
    logic at_eol_c;
    logic last_c;
    logic accept_c;
    logic drop_c;

    // Post-reset settle time elapsed once the count reaches INIT_CYCLES.
    assign wait_done_c = ({1'b0, wait_cnt} + WAIT_CW'(1)) >= WAIT_CW'(INIT_CYCLES);
    assign at_eol_c    = (col == CW'(LINE_WIDTH - 1));
    // Last pixel of the priming line, or last pixel of the frame while running.
    assign last_c      = at_eol_c && ((state == ST_PRIME) || (row == CW'(FRAME_HEIGHT - 1)));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, FIFO strobes and accept/drop decisions.
    always_comb begin
        state_nx = state;
        fifo_wre = 1'b0;
        fifo_rde = 1'b0;
        fifo_din = 8'h00;
        accept_c = 1'b0;
        drop_c   = 1'b0;
        case (state)
            ST_WAIT: begin
                drop_c = in_valid;
                if (wait_done_c) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    accept_c = 1'b1;
                    fifo_wre = 1'b1;
                    state_nx = ST_PRIME;
                end
            end
            ST_PRIME, ST_RUN: begin
                if (in_valid) begin
                    if (in_sof && !last_c) begin
                        // Frame restarted early: abandon this frame and drain.
                        drop_c   = 1'b1;
                        state_nx = ST_FLUSH;
                    end else begin
                        accept_c = 1'b1;
                        fifo_wre = 1'b1;
                        fifo_rde = (state == ST_RUN);
                        if (last_c) begin
                            state_nx = (state == ST_PRIME) ? ST_RUN : ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                drop_c   = in_valid;
                fifo_rde = (occ != '0);
                if (occ <= OCC_W'(1)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_WAIT;
            end
        endcase

        // FIFO protection: no pop when empty, no push into a full FIFO without a pop.
        if (occ == '0) begin
            fifo_rde = 1'b0;
        end
        if ((occ == OCC_W'(LINE_WIDTH)) && !fifo_rde) begin
            fifo_wre = 1'b0;
        end
        if (fifo_wre) begin
            fifo_din = in_data;
        end

        if (!reset) begin
            state_nx = ST_WAIT;
            fifo_wre = 1'b0;
            fifo_rde = 1'b0;
            fifo_din = 8'h00;
            accept_c = 1'b0;
            drop_c   = 1'b0;
        end
    end

    // Init wait counter, pixel coordinates and FIFO occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            col      <= '0;
            row      <= '0;
            occ      <= '0;
        end else begin
            if ((state == ST_WAIT) && !wait_done_c) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            case ({fifo_wre, fifo_rde})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            if (accept_c) begin
                if (state == ST_IDLE) begin
                    // The start-of-frame pixel is (0,0); next expected is (1,0).
                    col <= CW'(1);
                    row <= '0;
                end else if (at_eol_c) begin
                    col <= '0;
                    row <= (last_c && (state == ST_RUN)) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Registered output pixel pair and drop pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_cur     <= 8'h00;
            out_prev    <= 8'h00;
            out_prev_ok <= 1'b0;
            out_col     <= '0;
            out_row     <= '0;
            drop_err    <= 1'b0;
        end else begin
            out_valid <= accept_c;
            drop_err  <= drop_c;
            if (accept_c) begin
                out_cur     <= in_data;
                out_prev    <= (state == ST_RUN) ? fifo_dout : 8'h00;
                out_prev_ok <= (state == ST_RUN);
                out_col     <= (state == ST_IDLE) ? '0 : col;
                out_row     <= (state == ST_IDLE) ? '0 : row;
            end
        end
    end

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Bench for line_delay_ctrl: line-buffer reference model, FIFO stand-in,
// directed literal scenarios and randomized traffic.
module tb_line_delay_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned INIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        fifo_wre;
    logic [7:0]  fifo_din;
    logic        fifo_rde;
    logic [7:0]  fifo_dout;
    logic        out_valid;
    logic [7:0]  out_cur;
    logic [7:0]  out_prev;
    logic        out_prev_ok;
    logic [11:0] out_col;
    logic [11:0] out_row;
    logic        drop_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_delay_ctrl #(
        .LINE_WIDTH  (W),
        .FRAME_HEIGHT(H),
        .INIT_CYCLES (INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .fifo_wre   (fifo_wre),
        .fifo_din   (fifo_din),
        .fifo_rde   (fifo_rde),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_cur    (out_cur),
        .out_prev   (out_prev),
        .out_prev_ok(out_prev_ok),
        .out_col    (out_col),
        .out_row    (out_row),
        .drop_err   (drop_err)
    );

    // First-word-fall-through line FIFO stand-in, reset with the system reset.
    logic [7:0] fmem [16];
    logic [3:0] fwp  = 4'd0;
    logic [3:0] frp  = 4'd0;
    int         fcnt = 0;

    always @(posedge clk) begin
        if (!reset) begin
            fwp  <= 4'd0;
            frp  <= 4'd0;
            fcnt <= 0;
        end else begin
            if (fifo_wre) begin
                fmem[fwp] <= fifo_din;
                fwp       <= fwp + 4'd1;
            end
            if (fifo_rde) begin
                frp <= frp + 4'd1;
            end
            fcnt <= fcnt + int'(fifo_wre) - int'(fifo_rde);
        end
    end

    assign fifo_dout = (fcnt != 0) ? fmem[frp] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position, remaining init wait, remaining drain
    // words and a copy of the previous line; checked every cycle.
    logic [7:0] prev_line [W];
    logic [7:0] cur_line  [W];
    int         m_wait  = INIT;
    int         m_drain = 0;
    int         m_col   = 0;
    int         m_row   = 0;
    bit         m_in    = 1'b0;
    bit         e_valid = 1'b0;
    bit         e_drop  = 1'b0;
    bit         e_ok    = 1'b0;
    logic [7:0] e_cur   = 8'h00;
    logic [7:0] e_prev  = 8'h00;
    int         e_col   = 0;
    int         e_row   = 0;

    initial begin
        bit         w;
        bit         r;
        bit         acc;
        bit         drp;
        bit         last;
        int         ac;
        int         ar;
        logic [7:0] pv;
        @(posedge clk);
        forever begin
            @(negedge clk);
            w = 1'b0; r = 1'b0; acc = 1'b0; drp = 1'b0;
            ac = 0; ar = 0; pv = 8'h00;
            if (!reset) begin
                m_wait  = INIT;
                m_drain = 0;
                m_in    = 1'b0;
            end else if (m_wait > 0) begin
                drp = in_valid;
                m_wait--;
            end else if (m_drain > 0) begin
                r   = 1'b1;
                drp = in_valid;
                m_drain--;
            end else if (!m_in) begin
                if (in_valid && in_sof) begin
                    acc  = 1'b1;
                    m_in = 1'b1;
                    m_col = 0;
                    m_row = 0;
                end
            end else if (in_valid) begin
                last = (m_col == W - 1) && (m_row == 0 || m_row == H - 1);
                if (in_sof && !last) begin
                    drp     = 1'b1;
                    m_in    = 1'b0;
                    m_drain = (m_row == 0) ? m_col : W;
                end else begin
                    acc = 1'b1;
                end
            end
            if (acc) begin
                ac = m_col;
                ar = m_row;
                w  = 1'b1;
                r  = (ar > 0);
                pv = (ar > 0) ? prev_line[ac] : 8'h00;
                cur_line[ac] = in_data;
                if (ac == W - 1) begin
                    prev_line = cur_line;
                end
                if (ac == W - 1 && ar == H - 1) begin
                    m_in    = 1'b0;
                    m_drain = W;
                end else if (ac == W - 1) begin
                    m_col = 0;
                    m_row = ar + 1;
                end else begin
                    m_col = ac + 1;
                    m_row = ar;
                end
            end

            chk("fifo_wre", 32'(fifo_wre), 32'(w));
            chk("fifo_rde", 32'(fifo_rde), 32'(r));
            if (w) chk("fifo_din", 32'(fifo_din), 32'(in_data));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("drop_err", 32'(drop_err), 32'(e_drop));
            chk("out_cur", 32'(out_cur), 32'(e_cur));
            chk("out_prev", 32'(out_prev), 32'(e_prev));
            chk("out_prev_ok", 32'(out_prev_ok), 32'(e_ok));
            chk("out_col", 32'(out_col), e_col);
            chk("out_row", 32'(out_row), e_row);

            if (!reset) begin
                e_valid = 1'b0; e_drop = 1'b0; e_ok = 1'b0;
                e_cur = 8'h00; e_prev = 8'h00; e_col = 0; e_row = 0;
            end else begin
                e_valid = acc;
                e_drop  = drp;
                if (acc) begin
                    e_cur  = in_data;
                    e_prev = pv;
                    e_ok   = (ar > 0);
                    e_col  = ac;
                    e_row  = ar;
                end
            end
        end
    end

    task automatic cyc(input bit v, input bit s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Count FIFO pops over n idle-ish cycles; optionally inject a pixel on cycle 1.
    task automatic drain(input string name, input bit poke);
        int nrde;
        bit anyw;
        nrde = 0;
        anyw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = poke && (i == 1);
            in_sof   = 1'b0;
            in_data  = 8'hAA;
            #1;
            nrde += int'(fifo_rde);
            anyw |= fifo_wre;
            @(posedge clk);
            #1;
            if (poke && i == 1) chk("drain_drop_err", 32'(drop_err), 1);
        end
        chk({name, "_rde_count"}, nrde, 4);
        chk({name, "_no_write"}, 32'(anyw), 0);
    endtask

    initial begin
        bit         v;
        bit         s;
        logic [7:0] d;

        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_col", 32'(out_col), 0);
        reset = 1'b1;

        // Cycles 0..1 idle, sof at cycle 2 lands in the init wait.
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h55);
        chk("wait_drop_err", 32'(drop_err), 1);
        chk("wait_drop_valid", 32'(out_valid), 0);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Contiguous frame 10..21.
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, k == 0, 8'(10 + k));
            chk("frame_valid", 32'(out_valid), 1);
            chk("frame_col", 32'(out_col), k % 4);
            chk("frame_row", 32'(out_row), k / 4);
            chk("frame_prev_ok", 32'(out_prev_ok), (k >= 4) ? 1 : 0);
            if (k == 6) begin
                chk("pix21_cur", 32'(out_cur), 16);
                chk("pix21_prev", 32'(out_prev), 12);
            end
            if (k == 11) begin
                chk("pix32_cur", 32'(out_cur), 21);
                chk("pix32_prev", 32'(out_prev), 17);
            end
        end
        drain("frame_end", 1'b1);

        // Premature sof at (1,1).
        for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, 8'(100 + k));
        cyc(1'b1, 1'b1, 8'hEE);
        chk("premature_drop_err", 32'(drop_err), 1);
        chk("premature_valid", 32'(out_valid), 0);
        drain("premature", 1'b0);

        // Gapped frame (one pixel every three cycles) restarting at (0,0).
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, k == 0, 8'(10 + k));
            chk("gap_valid", 32'(out_valid), 1);
            if (k == 0) begin
                chk("restart_col", 32'(out_col), 0);
                chk("restart_row", 32'(out_row), 0);
            end
            chk("gap_cur", 32'(out_cur), 10 + k);
            chk("gap_prev", 32'(out_prev), (k >= 4) ? 6 + k : 0);
            cyc(1'b0, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 8'h00);
        end
        repeat (4) cyc(1'b0, 1'b0, 8'h00);

        // Reset asserted while running (row 1).
        for (int k = 0; k < 6; k++) cyc(1'b1, k == 0, 8'(k + 1));
        reset = 1'b0;
        cyc(1'b1, 1'b0, 8'h33);
        chk("rst_run_valid", 32'(out_valid), 0);
        chk("rst_run_cur", 32'(out_cur), 0);
        chk("rst_run_prev", 32'(out_prev), 0);
        chk("rst_run_row", 32'(out_row), 0);
        chk("rst_run_rde", 32'(fifo_rde), 0);
        chk("rst_run_wre", 32'(fifo_wre), 0);
        reset = 1'b1;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            v = ($urandom_range(0, 9) < 7);
            s = v && ($urandom_range(0, 19) == 0);
            d = 8'($urandom_range(0, 255));
            cyc(v, s, d);
        end
        reset = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
